serial_comp_ctrl: RTL
=====================

SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits; legal values are even and at least 2.
REQ-002 SHALL provide parameter EARLY_EXIT, default 1; 1 ends the compare at the first unequal slice, 0 always scans every slice.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL provide port start  input  1  request to compare; sampled only in IDLE.
REQ-006 SHALL provide port a  input  WIDTH  operand A, unsigned; sampled on the accepting edge.
REQ-007 SHALL provide port b  input  WIDTH  operand B, unsigned; sampled on the accepting edge.
REQ-008 SHALL provide port busy  output  1  high while in state RUN.
REQ-009 SHALL provide port done  output  1  one-cycle pulse; high only in state DONE.
REQ-010 SHALL provide port gt  output  1  registered result, A > B.
REQ-011 SHALL provide port eq  output  1  registered result, A == B.
REQ-012 SHALL provide port lt  output  1  registered result, A < B.
REQ-013 SHALL provide port slices  output  clog2(WIDTH/2)+1  number of 2-bit slices evaluated for the last result.

Function
REQ-014 SHALL implement three states: IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE with start=1 at an edge, load a and b into internal shift registers, clear gt/eq/lt/slices to 0 and enter RUN; start=1 has no effect outside IDLE.
REQ-016 SHALL, on each RUN edge, compare the current 2-bit slice (A and B slices), starting at bits [WIDTH-1:WIDTH-2], using the 2-bit gt/eq/lt function, then shift both registers left by 2 and increment slices.
REQ-017 SHALL, when EARLY_EXIT=1 and the slice is unequal, register gt or lt from that slice and enter DONE on the same edge.
REQ-018 SHALL, when EARLY_EXIT=0, latch the first unequal slice result in a sticky flag, ignore later slices, and register the result after the last slice.
REQ-019 SHALL, after the last slice (index WIDTH/2-1) with all slices equal, register eq=1 and enter DONE.
REQ-020 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-021 SHALL keep exactly one of gt/eq/lt high from entry to DONE until the next accepted start, and keep all three at 0 while busy.
REQ-022 SHALL, for start-to-done latency, assert done k+1 cycles after the accepting edge, where k = slices evaluated (1..WIDTH/2); the fixed latency with EARLY_EXIT=0 is WIDTH/2+1.
REQ-023 SHALL tolerate changes on a and b after the accepting edge with no effect on the result in progress.
REQ-024 SHALL ignore start asserted in DONE; a new compare requires start=1 in IDLE, so back-to-back throughput is one compare per k+2 cycles.

Reset
REQ-025 SHALL, on any edge with rst_n=0, force state IDLE, busy=0, done=0, gt=eq=lt=0, slices=0 and clear the shift registers, regardless of state.
REQ-026 SHALL, when reset is applied mid-RUN, discard the compare in progress and produce no done pulse; start is honoured on the first edge with rst_n=1.

Verification
REQ-027 SHALL cover this scenario (WIDTH=8, EARLY_EXIT=1): a=8'hA5, b=8'hA5, start pulse -> busy for 4 cycles, done 5 cycles after accept, eq=1, gt=lt=0, slices=4.
REQ-028 SHALL cover this scenario: a=8'hC0, b=8'h40 -> MSB slice differs, done 2 cycles after accept, gt=1, slices=1.
REQ-029 SHALL cover this scenario: a=8'h12, b=8'h13 -> done 5 cycles after accept, lt=1, slices=4; repeat with EARLY_EXIT=0 and a=8'h80, b=8'h00 -> gt=1, slices=4, latency 5.
REQ-030 SHALL cover this scenario: start held high continuously with a changing each cycle -> a new compare is accepted only in IDLE, results match the operands captured at each accept, and no done is lost or duplicated.
REQ-031 SHALL cover this scenario: rst_n=0 for one edge during the 2nd RUN cycle -> next cycle all outputs are 0 and state is IDLE, with no done pulse.
REQ-032 SHALL cover this scenario: 10,000 random a/b pairs checked against a reference model -> results, latency and slices all match, with exactly one of gt/eq/lt high on every done.

Source files
------------

// File: rtl/serial_comp_ctrl.sv
// Serial magnitude comparator: scans two operands MSB-first, two bits per cycle,
// and reports a registered gt/eq/lt result with the number of slices examined.
module serial_comp_ctrl #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1,
    localparam int SW        = $clog2(WIDTH/2) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [SW-1:0]    slices
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [SW-1:0] LAST = SW'(WIDTH/2 - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [1:0]       ha, hb;
    logic             sl_gt, sl_lt, last;
    logic             sticky, sticky_gt;
    logic             fin, res_gt, res_lt;

    assign ha    = sa[WIDTH-1 -: 2];
    assign hb    = sb[WIDTH-1 -: 2];
    assign sl_gt = ha > hb;
    assign sl_lt = ha < hb;
    assign last  = (slices == LAST);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Full-scan mode keeps the first unequal slice in a sticky flag so later
    // slices cannot overturn it; the result is only committed on the last slice.
    always_comb begin
        fin    = 1'b0;
        res_gt = 1'b0;
        res_lt = 1'b0;
        if (EARLY_EXIT != 0) begin
            fin    = last | sl_gt | sl_lt;
            res_gt = sl_gt;
            res_lt = sl_lt;
        end else begin
            fin    = last;
            res_gt = sticky ? sticky_gt  : sl_gt;
            res_lt = sticky ? !sticky_gt : sl_lt;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (fin) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            slices    <= '0;
            sticky    <= 1'b0;
            sticky_gt <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa        <= a;
                    sb        <= b;
                    gt        <= 1'b0;
                    eq        <= 1'b0;
                    lt        <= 1'b0;
                    slices    <= '0;
                    sticky    <= 1'b0;
                    sticky_gt <= 1'b0;
                end
                RUN: begin
                    sa     <= sa << 2;
                    sb     <= sb << 2;
                    slices <= slices + SW'(1);
                    if (!sticky && (sl_gt || sl_lt)) begin
                        sticky    <= 1'b1;
                        sticky_gt <= sl_gt;
                    end
                    if (fin) begin
                        gt <= res_gt;
                        lt <= res_lt;
                        eq <= !(res_gt || res_lt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
